// File: rtl/fifo_core_sc.sv
`default_nettype none
// ============================================================================
// Module   : fifo_core_sc
// Purpose  : Single-clock FIFO with wrap-bit pointers and combinational flags.
// Revision : 1.0
// ============================================================================
module fifo_core_sc #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             w_en,
    input  logic [WIDTH-1:0] data_in,
    input  logic             r_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic [SIZE:0]    wr_ptr,
    output logic [SIZE:0]    rd_ptr,
    output logic [SIZE:0]    count
);

    localparam int DEPTH = 2 ** SIZE;

    logic [WIDTH-1:0] mem [DEPTH];
    logic             w_acc;
    logic             r_acc;

    // Equal low bits with differing wrap bits means the writer is a full lap ahead.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[SIZE] != rd_ptr[SIZE]) &&
                   (wr_ptr[SIZE-1:0] == rd_ptr[SIZE-1:0]);
    assign count = wr_ptr - rd_ptr;

    assign w_acc = w_en & ~full;
    assign r_acc = r_en & ~empty;

    // Storage has no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (w_acc) begin
            mem[wr_ptr[SIZE-1:0]] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            data_out <= '0;
        end else begin
            if (w_acc) begin
                wr_ptr <= wr_ptr + (SIZE+1)'(1);
            end
            if (r_acc) begin
                data_out <= mem[rd_ptr[SIZE-1:0]];
                rd_ptr   <= rd_ptr + (SIZE+1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_core_sc.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_core_sc
// Purpose  : Directed self-checking bench for fifo_core_sc (SIZE=3, WIDTH=8).
// Revision : 1.0
// ============================================================================
module tb_fifo_core_sc;

    localparam int WIDTH = 8;
    localparam int SIZE  = 3;
    localparam int DEPTH = 2 ** SIZE;

    logic             clk;
    logic             arst_n;
    logic             w_en;
    logic [WIDTH-1:0] data_in;
    logic             r_en;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic [SIZE:0]    wr_ptr;
    logic [SIZE:0]    rd_ptr;
    logic [SIZE:0]    count;

    fifo_core_sc #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clk      (clk),
        .arst_n   (arst_n),
        .w_en     (w_en),
        .data_in  (data_in),
        .r_en     (r_en),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .wr_ptr   (wr_ptr),
        .rd_ptr   (rd_ptr),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [WIDTH-1:0] sb[$];
    logic [WIDTH-1:0] exp_dout;
    logic [SIZE:0]    exp_wp;
    logic [SIZE:0]    exp_rp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".data_out"}, 32'(data_out), 32'(exp_dout));
        check({tag, ".count"},    32'(count),    32'(sb.size()));
        check({tag, ".empty"},    32'(empty),    32'(sb.size() == 0));
        check({tag, ".full"},     32'(full),     32'(sb.size() == DEPTH));
        check({tag, ".wr_ptr"},   32'(wr_ptr),   32'(exp_wp));
        check({tag, ".rd_ptr"},   32'(rd_ptr),   32'(exp_rp));
    endtask

    task automatic model_reset();
        sb.delete();
        exp_dout = '0;
        exp_wp   = '0;
        exp_rp   = '0;
    endtask

    // One clock of stimulus; the expected word is queued on an accepted write
    // and popped when the accepted read delivers it one edge later.
    task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input string tag);
        bit wa;
        bit ra;
        wa      = w && (sb.size() < DEPTH);
        ra      = r && (sb.size() > 0);
        w_en    = w;
        data_in = d;
        r_en    = r;
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        if (ra) begin
            exp_dout = sb.pop_front();
            exp_rp   = exp_rp + 1'b1;
        end
        if (wa) begin
            sb.push_back(d);
            exp_wp = exp_wp + 1'b1;
        end
        check_state(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 arst_n = 1'b0;
        #1;
        model_reset();
        check_state(tag);
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_n  = 1'b1;
        w_en    = 1'b0;
        r_en    = 1'b0;
        data_in = '0;
        @(posedge clk);
        pulse_reset("reset");

        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h10 + i), 1'b0, "fill");
        step(1'b1, 8'hFF, 1'b0, "overflow");
        check("overflow.wr_ptr_lit", 32'(wr_ptr), 32'h8);

        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, "drain");
        step(1'b0, 8'h00, 1'b1, "underflow");
        check("underflow.dout_lit", 32'(data_out), 32'h17);

        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'(8'hA0 + i), 1'b0, "wrap_w");
            step(1'b0, 8'h00, 1'b1, "wrap_r");
        end

        step(1'b1, 8'h55, 1'b1, "simul_empty");
        step(1'b0, 8'h00, 1'b1, "simul_empty_rd");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0, "refill");
        step(1'b1, 8'hEE, 1'b1, "simul_full");
        check("simul_full.count_lit", 32'(count), 32'd7);
        step(1'b1, 8'h40, 1'b0, "simul_full_w");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, "drain2");

        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, "pre_reset");
        pulse_reset("mid_reset");
        step(1'b1, 8'h5A, 1'b0, "post_reset_w");
        step(1'b0, 8'h00, 1'b1, "post_reset_r");
        check("post_reset.dout_lit", 32'(data_out), 32'h5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
